// File: rtl/haar_lift_forward.sv
// Forward 1-D Haar lifting transform.
// Pairs a serial stream of signed samples (even, odd) and produces one
// detail coefficient d = odd - even and one approximation coefficient
// a = even + floor(d/2) per pair, each saturated to WIDTH bits.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | start low, input ignored; arms on the next start-high edge
// S_WAIT_EVEN| waiting for the even (first) sample of a pair
// S_WAIT_ODD | even sample held, waiting for the odd (second) sample
module haar_lift_forward #(
    parameter int WIDTH   = 16,
    parameter int ROW_LEN = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [WIDTH-1:0] pix_in,
    output logic [WIDTH-1:0] detail,
    output logic [WIDTH-1:0] approx,
    output logic             data_occur,
    output logic             row_done
);

    localparam int PAIRS = ROW_LEN / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_EVEN = 2'd1,
        S_WAIT_ODD  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;
    logic   accept_even;
    logic   accept_odd;

    logic [WIDTH-1:0] even_q;
    logic [CW-1:0]    pair_cnt;
    logic             pair_last;

    // Input pair register: the accepted even/odd samples, tagged with
    // whether this pair closes the row.
    logic             p0_vld;
    logic [WIDTH-1:0] p0_even;
    logic [WIDTH-1:0] p0_odd;
    logic             p0_last;

    // Stage 1: raw detail at WIDTH+1 bits and the matching even sample.
    logic             s1_vld;
    logic [WIDTH:0]   s1_d;
    logic [WIDTH-1:0] s1_even;
    logic             s1_last;

    logic signed [WIDTH:0] d_wide;
    logic signed [WIDTH:0] a_wide;

    // Clamp a WIDTH+1 bit signed value into WIDTH bits: overflow shows up
    // as the two top bits disagreeing, and the sign bit picks the rail.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] x);
        logic [WIDTH-1:0] r;
        if (x[WIDTH] != x[WIDTH-1]) begin
            r = x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            r = x[WIDTH-1:0];
        end
        return r;
    endfunction

    assign pair_last = (pair_cnt == LAST_PAIR);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and sample-accept decode; dropping start always returns
    // to IDLE, which discards any held even sample.
    always_comb begin
        state_nxt   = state_q;
        accept_even = 1'b0;
        accept_odd  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WAIT_EVEN;
                end
            end
            S_WAIT_EVEN: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end else if (pix_valid) begin
                    accept_even = 1'b1;
                    state_nxt   = S_WAIT_ODD;
                end
            end
            S_WAIT_ODD: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end else if (pix_valid) begin
                    accept_odd = 1'b1;
                    state_nxt  = S_WAIT_EVEN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Hold the even sample until its odd partner arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            even_q <= '0;
        end else if (accept_even) begin
            even_q <= pix_in;
        end
    end

    // Pair index within the row; cleared whenever start drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_cnt <= '0;
        end else if (!start) begin
            pair_cnt <= '0;
        end else if (accept_odd) begin
            if (pair_last) begin
                pair_cnt <= '0;
            end else begin
                pair_cnt <= pair_cnt + CW'(1);
            end
        end
    end

    // Hand the completed pair to the arithmetic pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_vld  <= 1'b0;
            p0_even <= '0;
            p0_odd  <= '0;
            p0_last <= 1'b0;
        end else begin
            p0_vld <= accept_odd;
            if (accept_odd) begin
                p0_even <= even_q;
                p0_odd  <= pix_in;
                p0_last <= pair_last;
            end
        end
    end

    assign d_wide = $signed({p0_odd[WIDTH-1], p0_odd}) - $signed({p0_even[WIDTH-1], p0_even});

    // Stage 1: unsaturated detail, kept one bit wider so the update step
    // sees the true difference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_d    <= '0;
            s1_even <= '0;
            s1_last <= 1'b0;
        end else begin
            s1_vld <= p0_vld;
            if (p0_vld) begin
                s1_d    <= d_wide;
                s1_even <= p0_even;
                s1_last <= p0_last;
            end
        end
    end

    // The sum cannot leave WIDTH+1 bits: |even| and |floor(d/2)| are both
    // bounded by 2^(WIDTH-1).
    assign a_wide = $signed({s1_even[WIDTH-1], s1_even}) + ($signed(s1_d) >>> 1);

    // Stage 2: saturate both coefficients and raise the strobes; the
    // coefficient registers hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            detail     <= '0;
            approx     <= '0;
            data_occur <= 1'b0;
            row_done   <= 1'b0;
        end else begin
            data_occur <= s1_vld;
            row_done   <= s1_vld & s1_last;
            if (s1_vld) begin
                detail <= sat(s1_d);
                approx <= sat(a_wide);
            end
        end
    end

endmodule

// File: tb/tb_haar_lift_forward.sv
// Bench for haar_lift_forward: a driver feeds samples and pushes expected
// coefficients (from a pair-level arithmetic model) into a queue, and a
// monitor pops and compares on every data_occur.
module tb_haar_lift_forward;

    localparam int W     = 16;
    localparam int RL    = 64;
    localparam int PAIRS = RL / 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         pix_valid;
    logic [W-1:0] pix_in;
    logic [W-1:0] detail;
    logic [W-1:0] approx;
    logic         data_occur;
    logic         row_done;

    haar_lift_forward #(.WIDTH(W), .ROW_LEN(RL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .detail     (detail),
        .approx     (approx),
        .data_occur (data_occur),
        .row_done   (row_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] a;
        logic         rd;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   strobes     = 0;
    int   rd_seen     = 0;

    // Reference model state: is the stream armed, the pending even sample,
    // and which pair of the row comes next.
    bit   m_armed     = 0;
    bit   m_have_even = 0;
    int   m_even      = 0;
    int   m_pair      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int floor_half(input int d);
        if (d >= 0) return d / 2;
        return -((-d + 1) / 2);
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Apply one cycle of input and advance the model by what the upcoming
    // edge should do to the stream.
    task automatic step(input bit s, input bit v, input logic [W-1:0] p);
        int   smp;
        int   d;
        exp_t e;
        start     = s;
        pix_valid = v;
        pix_in    = p;
        smp       = $signed(p);
        if (!s) begin
            m_armed     = 0;
            m_have_even = 0;
            m_pair      = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (v) begin
            if (!m_have_even) begin
                m_even      = smp;
                m_have_even = 1;
            end else begin
                d     = smp - m_even;
                e.d   = W'(clamp(d));
                e.a   = W'(clamp(m_even + floor_half(d)));
                e.rd  = (m_pair == PAIRS - 1);
                e.cyc = cyc + 3;
                sb.push_back(e);
                m_have_even = 0;
                m_pair      = (m_pair + 1) % PAIRS;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(start, 1'b0, 16'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) idle_cycles(1);
        idle_cycles(2);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] rnd_sample();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 16'h8000;
        if (sel == 1) return 16'h7FFF;
        return W'($urandom);
    endfunction

    // Compare every strobe against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_occur) begin
                strobes++;
                if (row_done) rd_seen++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_strobe: detail=%h approx=%h at cycle %0d with no pair pending",
                             detail, approx, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (detail !== e.d || approx !== e.a || row_done !== e.rd || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL coeff: got d=%h a=%h rd=%b cyc=%0d expected d=%h a=%h rd=%b cyc=%0d",
                                 detail, approx, row_done, cyc, e.d, e.a, e.rd, e.cyc);
                    end
                end
            end else if (row_done) begin
                vectors++;
                miscompares++;
                $display("FAIL row_done_alone: row_done=1 expected 0 without data_occur at cycle %0d", cyc);
            end
        end
    end

    initial begin
        int s0;
        int r0;
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_detail", detail, 0);
        check("reset_approx", approx, 0);
        check("reset_data_occur", data_occur, 0);
        check("reset_row_done", row_done, 0);
        reset = 1'b0;

        // Basic pairs and both saturation rails.
        step(1, 0, 16'h0);
        step(1, 1, 16'd10);
        step(1, 1, 16'd14);
        idle_cycles(3);
        check("pair_10_14_detail", detail, 4);
        check("pair_10_14_approx", approx, 12);
        step(1, 1, 16'd14);
        step(1, 1, 16'd10);
        idle_cycles(3);
        check("pair_14_10_detail", detail, 16'hFFFC);
        check("pair_14_10_approx", approx, 12);
        step(1, 1, 16'h8000);
        step(1, 1, 16'h7FFF);
        step(1, 1, 16'h7FFF);
        step(1, 1, 16'h8000);
        drain();

        // Two full rows with random gaps.
        step(0, 0, 16'h0);
        step(1, 0, 16'h0);
        s0 = strobes;
        r0 = rd_seen;
        for (int n = 0; n < 2 * RL; ) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1, 0, W'($urandom));
            end else begin
                step(1, 1, rnd_sample());
                n++;
            end
        end
        drain();
        check("two_rows_strobes", strobes - s0, RL);
        check("two_rows_row_done", rd_seen - r0, 2);

        // Orphan even sample, then restart.
        step(1, 1, 16'd55);
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        step(1, 0, 16'h0);
        step(1, 1, 16'd3);
        step(1, 1, 16'd7);
        drain();
        check("restart_detail", detail, 4);
        check("restart_approx", approx, 5);

        // start falls on the edge of the odd sample: nothing accepted.
        step(1, 1, 16'd20);
        s0 = strobes;
        step(0, 1, 16'd30);
        idle_cycles(4);
        check("start_fall_no_strobe", strobes - s0, 0);

        // Reset while a pair is in flight.
        step(1, 0, 16'h0);
        step(1, 1, 16'd100);
        step(1, 1, 16'd200);
        step(1, 0, 16'h0);
        reset = 1'b1;
        #1;
        sb.delete();
        m_armed     = 0;
        m_have_even = 0;
        m_pair      = 0;
        check("midreset_detail", detail, 0);
        check("midreset_approx", approx, 0);
        check("midreset_data_occur", data_occur, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        s0 = strobes;
        step(1, 0, 16'h0);
        idle_cycles(6);
        check("post_reset_no_strobe", strobes - s0, 0);

        // Random stream with occasional start drops.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0, rnd_sample());
        end
        step(1, 0, 16'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/haar_lift_forward.md
# haar_lift_forward

Forward 1-D Haar lifting transform: accepts a serial stream of signed samples, pairs them (even, odd) and emits one detail and one approximation coefficient per pair. It is the analysis-side counterpart of `haar_lift_reprocess`. Its `detail`/`approx` outputs feed that block's high and low coefficient inputs for perfect reconstruction, apart from saturated pairs. One instance processes one image row at a time, with row length set by parameter.

## Interface
- `WIDTH`, 16: sample and coefficient width, signed two's complement.
- `ROW_LEN`, 64: samples per row. Must be even and at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset; clears all state and outputs.
- `start`  in  1  level enable. While low, the block is idle and input is ignored.
- `pix_valid`  in  1  `pix_in` carries a sample this cycle.
- `pix_in`  in  WIDTH  input sample.
- `detail`  out  WIDTH  detail coefficient d.
- `approx`  out  WIDTH  approximation coefficient a.
- `data_occur`  out  1  one-cycle strobe; `detail`/`approx` are valid.
- `row_done`  out  1  one-cycle strobe, coincident with the `data_occur` of the last pair in a row.

## Operation
- FSM states:
  - IDLE: leave to WAIT_EVEN when `start`=1.
  - WAIT_EVEN: on `start`&`pix_valid`, latch `pix_in` as even, go to WAIT_ODD.
  - WAIT_ODD: on `start`&`pix_valid`, pass even/odd to the pipeline, go to WAIT_EVEN.
  - Any state with `start`=0: go to IDLE. A held even sample is discarded, the pair counter clears, and the pipeline still drains pairs already accepted.
- Cycles with `pix_valid`=0 are stalls: no state change and no sample consumed.
- Arithmetic, computed in WIDTH+1 bits:
  - d = odd − even.
  - a = even + (d >>> 1), an arithmetic shift, i.e. floor(d/2) on the unsaturated d.
  - d and a are each saturated independently to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Inverse relation, when not saturated: even = a − floor(d/2), odd = even + d.
- Pair counter:
  - Range 0..ROW_LEN/2−1; increments on each accepted odd sample.
  - Wraps to 0 after the last pair of a row.
  - `row_done` is flagged for the pair at index ROW_LEN/2−1.
- `detail`/`approx` hold their last values between strobes.

## Timing
- Reset values:
  - `detail`=0, `approx`=0, `data_occur`=0, `row_done`=0.
  - FSM = IDLE, pair counter = 0, pipeline valid bits = 0.
- Pipeline: two register stages.
  - Stage 1 registers d and even.
  - Stage 2 registers the saturated d and a, plus the strobes.
- Latency: if the odd sample is captured at edge N, then `data_occur`, `detail` and `approx` are valid after edge N+2, for exactly one cycle.
- Throughput: one pair every 2 valid cycles, with no back-pressure. Back-to-back strobes are impossible, so at most one strobe every 2 cycles.
- `start` rising edge: the first sample captured is the first one with `pix_valid`=1 at or after the edge where the FSM is in WAIT_EVEN, i.e. one edge after `start` is seen high in IDLE.
- `start` falls on the same edge as an odd sample: the sample is not accepted and no strobe follows.
- Reset asserted mid-pipeline: in-flight pairs are lost and outputs go to 0 immediately, asynchronously. After reset deasserts, the FSM restarts from IDLE.

## Test plan
- Reset, then `start`=1, samples 10, 14 on consecutive cycles:
  - `data_occur` pulses 2 edges after the 14 is captured.
  - `detail`=4, `approx`=12.
- Samples 14, 10:
  - `detail`=0xFFFC (−4), `approx`=12.
  - Feeding both outputs to `haar_lift_reprocess` reconstructs 14, 10.
- Saturation:
  - Samples 0x8000, 0x7FFF → `detail`=0x7FFF, `approx`=0xFFFF.
  - Samples 0x7FFF, 0x8000 → `detail`=0x8000, `approx`=0xFFFF.
- Full row, ROW_LEN=64, 64 samples with random `pix_valid` gaps:
  - Exactly 32 `data_occur` pulses.
  - `row_done` only on the 32nd pulse.
  - Coefficients match the reference model.
  - A second row restarts at pair 0.
- Drop `start` after one even sample, then restart with 3, 7:
  - No strobe for the orphan sample.
  - Next output is `detail`=4, `approx`=5.
- Assert `reset` one cycle after an odd sample is captured:
  - Outputs 0 at once.
  - No `data_occur` afterwards until new pairs arrive.
